// File: rtl/data_memory_64_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
// Carries address, store data, enables and size, plus load data and fault status.
interface data_memory_64_if;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  Funct3;
    logic [63:0] Read_Data;
    logic        Misaligned;
    logic        Access_Fault;
    logic        Fault_Sticky;
    logic [15:0] Store_Count;

    modport master (
        output Mem_Addr, Write_Data, MemWrite, MemRead, Funct3,
        input  Read_Data, Misaligned, Access_Fault, Fault_Sticky, Store_Count
    );

    modport slave (
        input  Mem_Addr, Write_Data, MemWrite, MemRead, Funct3,
        output Read_Data, Misaligned, Access_Fault, Fault_Sticky, Store_Count
    );
endinterface

// File: rtl/data_memory_64.sv
// Byte-addressable little-endian data memory for RV64I loads/stores.
// Combinational reads, edge-committed stores, fault detection with a sticky flag.
module data_memory_64 #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_LSB_W  = 8
) (
    input logic              clk,
    input logic              reset,
    data_memory_64_if.slave  bus
);

    logic [7:0]            mem_q [DEPTH_BYTES];
    logic                  fault_sticky_q, fault_sticky_d;
    logic [15:0]           store_count_q, store_count_d;

    logic                  access, illegal, misaligned, out_of_range, fault, store_ok;
    logic [7:0]            be;
    logic [2:0]            align_mask;
    logic [ADDR_LSB_W-1:0] base;
    logic [63:0]           raw, rdata;
    logic                  sx;

    always_comb begin
        access  = bus.MemRead | bus.MemWrite;
        illegal = (bus.Funct3 == 3'b111) | (bus.MemWrite & bus.Funct3[2]);

        case (bus.Funct3[1:0])
            2'b00:   be = 8'h01;
            2'b01:   be = 8'h03;
            2'b10:   be = 8'h0F;
            default: be = 8'hFF;
        endcase
        // Low address bits that must be zero: size-1, taken from the byte-enable pattern.
        align_mask = {be[4], be[2], be[1]};

        misaligned   = access & ~illegal & (|(bus.Mem_Addr[2:0] & align_mask));
        out_of_range = access & (|bus.Mem_Addr[63:ADDR_LSB_W]);
        fault        = misaligned | out_of_range | (access & illegal);
        store_ok     = bus.MemWrite & ~fault;

        base = bus.Mem_Addr[ADDR_LSB_W-1:0];
        raw  = '0;
        for (int k = 0; k < 8; k++) begin
            raw[8*k +: 8] = mem_q[base + ADDR_LSB_W'(k)];
        end

        sx = ~bus.Funct3[2];
        case (bus.Funct3[1:0])
            2'b00:   rdata = {{56{sx & raw[7]}},  raw[7:0]};
            2'b01:   rdata = {{48{sx & raw[15]}}, raw[15:0]};
            2'b10:   rdata = {{32{sx & raw[31]}}, raw[31:0]};
            default: rdata = raw;
        endcase

        store_count_d  = store_ok ? store_count_q + 16'd1 : store_count_q;
        fault_sticky_d = fault_sticky_q | fault;
    end

    assign bus.Read_Data    = (bus.MemRead & ~fault) ? rdata : '0;
    assign bus.Misaligned   = misaligned;
    assign bus.Access_Fault = fault;
    assign bus.Fault_Sticky = fault_sticky_q;
    assign bus.Store_Count  = store_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH_BYTES; k++) begin
                mem_q[ADDR_LSB_W'(k)] <= '0;
            end
            fault_sticky_q <= 1'b0;
            store_count_q  <= '0;
        end else begin
            if (store_ok) begin
                for (int k = 0; k < 8; k++) begin
                    if (be[k]) begin
                        mem_q[base + ADDR_LSB_W'(k)] <= bus.Write_Data[8*k +: 8];
                    end
                end
            end
            fault_sticky_q <= fault_sticky_d;
            store_count_q  <= store_count_d;
        end
    end

endmodule
